// File: rtl/pipe_buf_pkg.sv
// Shared definitions for the two-slot pipeline stage buffer: state encoding,
// default bubble control value and the per-cycle handshake event bundle.
package pipe_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int unsigned DEF_BUBBLE_CTRL = 0;

  typedef struct packed {
    logic acc;
    logic ret;
    logic flush;
  } buf_evt_t;

  // The state encoding doubles as the held-entry count.
  function automatic logic [1:0] occ_of(input buf_state_e s);
    return logic'(s == ST_FULL) ? 2'd2 : (s == ST_HALF) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream handshake bundle of a pipeline stage buffer.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12,
  parameter int RD_W   = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        occupancy;

  // Environment side: feeds entries in, consumes entries out.
  modport master (
    output in_valid, in_data, in_ctrl, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_rd, occupancy
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, in_ctrl, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_rd, occupancy
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-slot (main + skid) pipeline stage buffer with registered in_ready,
// bubble insertion on empty, and a synchronous highest-priority flush.
module pipe_stage_buf
  import pipe_buf_pkg::*;
#(
  parameter int               DATA_W      = 32,
  parameter int               CTRL_W      = 12,
  parameter int               RD_W        = 6,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(DEF_BUBBLE_CTRL)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  pipe_stage_buf_if.slave bus
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [RD_W-1:0]   main_rd_q,   main_rd_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [RD_W-1:0]   skid_rd_q,   skid_rd_d;

  logic     in_ready_w, out_valid_w;
  buf_evt_t evt;

  // Handshake flags depend on registered state only, so no input reaches in_ready.
  assign in_ready_w  = (state_q != ST_FULL);
  assign out_valid_w = (state_q != ST_EMPTY);

  assign evt.acc   = bus.in_valid && in_ready_w;
  assign evt.ret   = out_valid_w && bus.out_ready;
  assign evt.flush = flush;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_rd_d   = main_rd_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rd_d   = skid_rd_q;

    if (evt.flush) begin
      // Squash both slots; the bubble is loaded into main so outputs stay registered.
      state_d     = ST_EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_rd_d   = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
      skid_rd_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (evt.acc) begin
            state_d     = ST_HALF;
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
            main_rd_d   = bus.in_rd;
          end
        end
        ST_HALF: begin
          case ({evt.acc, evt.ret})
            2'b11: begin
              main_data_d = bus.in_data;
              main_ctrl_d = bus.in_ctrl;
              main_rd_d   = bus.in_rd;
            end
            2'b10: begin
              state_d     = ST_FULL;
              skid_data_d = bus.in_data;
              skid_ctrl_d = bus.in_ctrl;
              skid_rd_d   = bus.in_rd;
            end
            2'b01: begin
              // Data is left as-is; only ctrl/rd must show a bubble.
              state_d     = ST_EMPTY;
              main_ctrl_d = BUBBLE_CTRL;
              main_rd_d   = '0;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (evt.ret) begin
            state_d     = ST_HALF;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            main_rd_d   = skid_rd_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
      main_rd_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_rd_q   <= main_rd_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_rd    = main_rd_q;
  assign bus.occupancy = occ_of(state_q);

endmodule
